// File: rtl/sample_pkg.sv
// Shared types and defaults for the __sample__main result path.
package sample_pkg;
  localparam int unsigned SAMPLE_DATA_WIDTH = 32;
  typedef logic [SAMPLE_DATA_WIDTH-1:0] sample_word_t;
  localparam int unsigned SAMPLE_FIFO_DEPTH_DEFAULT = 4;
endpackage

// File: rtl/sample_sat_counter.sv
// Saturating incrementer; holds at all-ones once reached.
module sample_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/sample_result_fifo.sv
// Elastic ready/valid output stage behind a no-backpressure producer; drops on full.
// Optional drop/high-water statistics: define SAMPLE_RESULT_FIFO_STATS_EN.
module sample_result_fifo
  import sample_pkg::*;
#(
  parameter int unsigned DEPTH      = SAMPLE_FIFO_DEPTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = SAMPLE_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow,
  input  logic                         clr_overflow
`ifdef SAMPLE_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]                  drop_count,
  output logic [$clog2(DEPTH+1)-1:0]   high_water
`endif
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_next;
  logic                  full;
  logic                  pop;
  logic                  accept;
  logic                  drop;

  assign full      = (occ == OCC_W'(DEPTH));
  assign out_valid = (occ != '0);
  assign out_data  = mem[rd_ptr];
  assign occupancy = occ;
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign accept    = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  always_comb begin
    occ_next = occ;
    if (accept && !pop) begin
      occ_next = occ + 1'b1;
    end else if (pop && !accept) begin
      occ_next = occ - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ_next;
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef SAMPLE_RESULT_FIFO_STATS_EN
  logic [OCC_W-1:0] peak;

  sample_sat_counter #(
    .WIDTH(16)
  ) u_drop_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .count (drop_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (occ_next > peak) begin
      peak <= occ_next;
    end
  end

  assign high_water = peak;
`endif
endmodule

// File: tb/tb_sample_result_fifo.sv
// Randomized + directed scoreboard bench for sample_result_fifo (DEPTH=4).
module tb_sample_result_fifo;
  localparam int DEPTH = 4;
  localparam int OCC_W = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [OCC_W-1:0] occupancy;
  logic             overflow;
  logic             clr_overflow;
`ifdef SAMPLE_RESULT_FIFO_STATS_EN
  logic [15:0]      drop_count;
  logic [OCC_W-1:0] high_water;
`endif

  sample_result_fifo #(
    .DEPTH(DEPTH),
    .DATA_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .occupancy    (occupancy),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef SAMPLE_RESULT_FIFO_STATS_EN
    ,
    .drop_count   (drop_count),
    .high_water   (high_water)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: expected word order plus abstract counters.
  logic [31:0] sb_q[$];
  int          m_cnt;
  bit          m_ovf;
  int          m_drops;
  int          m_hw;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_drops = 0;
    m_hw    = 0;
  endtask

  // Monitor: sample mid-cycle, compare against model, retire words consumed on the next edge.
  always @(negedge clk) begin
    check("out_valid", 64'(out_valid), 64'(m_cnt != 0));
    check("occupancy", 64'(occupancy), 64'(m_cnt));
    check("overflow", 64'(overflow), 64'(m_ovf));
`ifdef SAMPLE_RESULT_FIFO_STATS_EN
    check("drop_count", 64'(drop_count), 64'(m_drops));
    check("high_water", 64'(high_water), 64'(m_hw));
`endif
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_underrun", 64'(out_valid), 64'(0));
      end else begin
        check("head_data", 64'(out_data), 64'(sb_q[0]));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  // Drive one cycle; update the model from the stimulus seen at the edge.
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit clr);
    bit pop;
    bit acc;
    in_valid     = v;
    in_data      = d;
    out_ready    = r;
    clr_overflow = clr;
    @(posedge clk);
    pop = (m_cnt > 0) && r;
    acc = v && ((m_cnt < DEPTH) || pop);
    if (acc) sb_q.push_back(d);
    m_cnt = m_cnt + int'(acc) - int'(pop);
    if (v && !acc) begin
      m_ovf = 1'b1;
      if (m_drops < 65535) m_drops++;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    if (m_cnt > m_hw) m_hw = m_cnt;
    #1;
  endtask

  // Reset pulse strictly between edges; outputs must clear without a clock.
  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0);

    // Single push, hold, then consume.
    step(1, 32'h2a, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    check("single_hold_data", 64'(out_data), 64'h2a);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Streaming with wrap at full throughput.
    for (int i = 0; i < 20; i++) step(1, 32'(i), 1, 0);
    step(0, 0, 1, 0);
`ifdef SAMPLE_RESULT_FIFO_STATS_EN
    check("stream_high_water_le1", 64'(high_water <= 1), 64'(1));
`endif

    // Fill to overflow, then drain in order.
    for (int i = 1; i <= 5; i++) step(1, 32'(i), 0, 0);
    check("fill_occ", 64'(occupancy), 64'(DEPTH));
    check("fill_ovf", 64'(overflow), 64'(1));
    repeat (5) step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) step(1, 32'(i), 0, 0);
    step(1, 32'd5, 1, 0);
    check("full_pp_occ", 64'(occupancy), 64'(DEPTH));
    check("full_pp_ovf", 64'(overflow), 64'(0));
    repeat (5) step(0, 0, 1, 0);

    // Clear versus set priority.
    for (int i = 1; i <= 4; i++) step(1, 32'(i + 16), 0, 0);
    step(1, 32'h99, 0, 1);
    check("clr_set_prio", 64'(overflow), 64'(1));
    step(0, 0, 0, 1);
    check("clr_alone", 64'(overflow), 64'(0));
    repeat (4) step(0, 0, 1, 0);

    // Mid-stream reset.
    for (int i = 0; i < 3; i++) step(1, 32'(i + 100), 0, 0);
    async_reset();
    step(1, 32'h2a, 0, 0);
    check("post_rst_head", 64'(out_data), 64'h2a);
    step(0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 3) != 0), $urandom(),
           bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 9) == 0));
    end
    repeat (6) step(0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sample_result_fifo.md
# sample_result_fifo

Elastic output stage directly downstream of the `__sample__main` pipeline. Upstream has no backpressure: it presents `output_valid`/`out[31:0]` every cycle it fires. This block captures each valid word into a small FIFO and re-presents it on a ready/valid interface for consumers that can stall. Words that arrive while the FIFO is full and not draining are dropped and flagged, never silently overwritten.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `DATA_WIDTH`, default 32: word width; matches upstream `out`.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_valid`  in  1: driven by upstream `output_valid`.
- `in_data`  in  DATA_WIDTH: driven by upstream `out`.
- `out_valid`  out  1: FIFO non-empty; head word presented.
- `out_ready`  in  1: consumer accepts head word.
- `out_data`  out  DATA_WIDTH: head word.
- `occupancy`  out  $clog2(DEPTH+1): entries held, 0..DEPTH.
- `overflow`  out  1: sticky; set when a word is dropped.
- `clr_overflow`  in  1: synchronous clear of `overflow`.
- `drop_count`  out  16: dropped words, saturating (only with `SAMPLE_RESULT_FIFO_STATS_EN`).
- `high_water`  out  $clog2(DEPTH+1): maximum occupancy since reset (only with `SAMPLE_RESULT_FIFO_STATS_EN`).

## Operation
- Reset (`rst_n` low, asynchronous):
  - Pointers, occupancy, `overflow` and statistics go to 0.
  - Storage is cleared to 0.
  - Therefore `out_valid`=0, `out_data`=0, `occupancy`=0 while in reset.
- Push attempt: `in_valid`=1. Pop: `out_valid && out_ready`.
- Not full, push: write `in_data` at write pointer, advance write pointer.
- Pop: advance read pointer.
- Full, push and pop in the same cycle: both take effect; the word is accepted and occupancy stays DEPTH.
- Full, push without pop: the word is dropped; no state changes except `overflow`←1 and drop statistics.
- Empty, pop: impossible, since `out_valid`=0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by a separate counter, not by pointer difference.
- `out_data` = storage[read pointer]. It is stable while `out_valid`=1 and `out_ready`=0.
- `overflow`: set has priority over `clr_overflow` in the same cycle.
- `rst_n` asserted mid-stream discards all held words immediately. The first push after deassertion behaves as a push into an empty FIFO.

## Timing
- Latency from push to visibility is 1 cycle. A word pushed into an empty FIFO at edge N gives `out_valid`=1 after edge N. There is no combinational bypass from `in_*` to `out_*`.
- `out_ready` has no combinational path to any output other than via registered state. `out_valid` and `out_data` come from registers and storage only.
- `occupancy`, `overflow` and statistics update on the same edge as the push or pop causing them.
- Sustained throughput is 1 word/cycle when `out_ready` is held high, at any fill level.

## Configuration
- `SAMPLE_RESULT_FIFO_STATS_EN` defined:
  - `drop_count` increments on each dropped word and saturates at 16'hFFFF.
  - `drop_count` is cleared by reset only, not by `clr_overflow`.
  - `high_water` tracks peak occupancy and resets to 0.
- `SAMPLE_RESULT_FIFO_STATS_EN` undefined:
  - `drop_count` and `high_water` ports are absent.
  - No counter logic is elaborated.
  - All other behaviour is identical.

## Structure
- Shared package `sample_pkg`:
  - `SAMPLE_DATA_WIDTH` = 32.
  - `typedef logic [SAMPLE_DATA_WIDTH-1:0] sample_word_t`.
  - `SAMPLE_FIFO_DEPTH_DEFAULT` = 4.
- One sub-module, `sample_sat_counter`: a parameterised-width saturating incrementer with async active-low reset. It is used for `drop_count`, inside the `SAMPLE_RESULT_FIFO_STATS_EN` guard.
- Storage, pointers and occupancy live in the top module.

## Test plan
- Reset then single push:
  - Stimulus: `in_valid`=1 for 1 cycle with `in_data`=32'h2a, `out_ready`=0.
  - Response: one cycle later `out_valid`=1, `out_data`=32'h2a, `occupancy`=1. Both hold until `out_ready`=1; the following cycle gives `out_valid`=0.
- Fill to overflow with `out_ready`=0, DEPTH=4:
  - Stimulus: push 1,2,3,4,5.
  - Response: `occupancy`=4, `overflow`=1 after the 5th push, `drop_count`=1. Draining then yields 1,2,3,4 in order.
- Full with simultaneous push and pop:
  - Stimulus: FIFO holds 1..4; push 5 with `out_ready`=1.
  - Response: `occupancy` stays 4, `overflow` stays 0, subsequent drain yields 2,3,4,5.
- Streaming with wrap-around:
  - Stimulus: 20 consecutive pushes of 0..19 with `out_ready`=1 throughout.
  - Response: output is 0..19 in order at 1/cycle with 1-cycle latency; `high_water` ≤ 1; no drops.
- Clear versus set priority:
  - Stimulus: assert `clr_overflow` in the same cycle as a drop.
  - Response: `overflow` stays 1. Asserting `clr_overflow` alone next cycle gives `overflow`=0, while `drop_count` is unchanged.
- Mid-stream reset:
  - Stimulus: FIFO holds 3 words; pulse `rst_n` low between edges.
  - Response: `out_valid`, `occupancy` and `out_data` go to 0 immediately, without waiting for a clock edge. Pushing 32'h2a afterwards gives head 32'h2a.
